// File: rtl/uart_frame_ctrl.sv
// UART frame sequencer: collect words, run engine, stream results.
// Timed receive abort and level-safe transmit handshake.
module uart_frame_ctrl #(
  parameter int NUM_DATA   = 2500,
  parameter int ADDR_W     = 14,
  parameter int WORD_BYTES = 1,
  parameter int RX_TIMEOUT = 960000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_ready,
  input  logic                    tx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_waddr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic [ADDR_W-1:0]       res_raddr,
  input  logic [8*WORD_BYTES-1:0] res_rdata,
  output logic                    proc_start,
  input  logic                    proc_done,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err_timeout
);

  localparam int DW = 8 * WORD_BYTES;
  localparam logic [ADDR_W-1:0] LAST_W = ADDR_W'(NUM_DATA - 1);
  localparam logic [1:0] LAST_B = 2'(WORD_BYTES - 1);
  localparam logic [31:0] TMO = 32'(RX_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, COLLECT, PSTART, PWAIT, SEND, DONE
  } state_t;

  state_t            state_q, state_d;
  logic              rx_prev_q;
  logic [1:0]        bidx_q, bidx_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              first_q, first_d;
  logic              txs_q, txs_d;
  logic [7:0]        txd_q, txd_d;

  logic       accept;
  logic       store;
  logic [7:0] byte_sel;

  assign accept = rx_ready & ~rx_prev_q;

  // Pick the result byte addressed by the byte index
  always_comb begin
    byte_sel = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (bidx_q == 2'(k)) byte_sel = res_rdata[8*k +: 8];
    end
  end

  // Next-state, datapath and handshake control
  always_comb begin
    state_d = state_q;
    bidx_d  = bidx_q;
    widx_d  = widx_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    raddr_d = raddr_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    first_d = first_q;
    txs_d   = txs_q;
    txd_d   = txd_q;
    store   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          store   = 1'b1;
          err_d   = 1'b0;
          tmo_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (we_q && waddr_q == LAST_W) begin
          tmo_d   = '0;
          state_d = PSTART;
        end else if (accept) begin
          store = 1'b1;
          tmo_d = '0;
        end else if (TMO != '0 && tmo_q + 32'd1 == TMO) begin
          err_d   = 1'b1;
          bidx_d  = '0;
          widx_d  = '0;
          waddr_d = '0;
          wdata_d = '0;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      PSTART: begin
        first_d = 1'b1;
        state_d = PWAIT;
      end
      PWAIT: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (proc_done) begin
          raddr_d = '0;
          bidx_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!txs_q) begin
          if (tx_ready) begin
            txs_d = 1'b1;
            txd_d = byte_sel;
          end
        end else if (!tx_ready) begin
          txs_d = 1'b0;
          if (bidx_q == LAST_B) begin
            bidx_d = '0;
            if (raddr_q == LAST_W) state_d = DONE;
            else raddr_d = raddr_q + 1'b1;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
      DONE: begin
        raddr_d = '0;
        waddr_d = '0;
        widx_d  = '0;
        bidx_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (store) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (bidx_q == 2'(k)) wdata_d[8*k +: 8] = rx_data;
      end
      if (bidx_q == LAST_B) begin
        bidx_d  = '0;
        we_d    = 1'b1;
        waddr_d = widx_q;
        if (widx_q != LAST_W) widx_d = widx_q + 1'b1;
      end else begin
        bidx_d = bidx_q + 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rx_prev_q <= 1'b0;
      bidx_q    <= '0;
      widx_q    <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      raddr_q   <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
      txs_q     <= 1'b0;
      txd_q     <= '0;
    end else begin
      state_q   <= state_d;
      rx_prev_q <= rx_ready;
      bidx_q    <= bidx_d;
      widx_q    <= widx_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      raddr_q   <= raddr_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      first_q   <= first_d;
      txs_q     <= txs_d;
      txd_q     <= txd_d;
    end
  end

  assign tx_data     = txd_q;
  assign tx_start    = txs_q;
  assign mem_we      = we_q;
  assign mem_waddr   = waddr_q;
  assign mem_wdata   = wdata_q;
  assign res_raddr   = raddr_q;
  assign proc_start  = (state_q == PSTART);
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl.
// Memory writes and transmitted bytes are checked against queues.
module tb_uart_frame_ctrl;

  localparam int NUM = 3;
  localparam int AW  = 4;
  localparam int WB  = 2;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready = 1'b0;
  logic          tx_ready = 1'b1;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;
  logic [AW-1:0] res_raddr;
  logic [15:0]   res_rdata;
  logic          proc_start;
  logic          proc_done = 1'b0;
  logic          busy;
  logic          frame_done;
  logic          err_timeout;

  uart_frame_ctrl #(
    .NUM_DATA(NUM), .ADDR_W(AW),
    .WORD_BYTES(WB), .RX_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_start(tx_start), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .res_raddr(res_raddr), .res_rdata(res_rdata),
    .proc_start(proc_start), .proc_done(proc_done),
    .busy(busy), .frame_done(frame_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  wr_t        wr_e;

  logic [15:0] res_mem [0:15];
  logic [15:0] in_w  [NUM];
  logic [15:0] out_w [NUM];

  assign res_rdata = res_mem[res_raddr];

  int proc_cnt = 0;
  int proc_cyc = 0;
  int fd_cnt = 0;
  int last_rx_cyc = 0;

  // Write scoreboard, exclusivity and pulse counters
  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) begin
        n_checks++;
        if (exp_wr.size() == 0) begin
          n_fail++;
          $display("FAIL wr_extra addr=%0h data=%0h expected none",
                   mem_waddr, mem_wdata);
        end else begin
          wr_e = exp_wr.pop_front();
          if (mem_waddr !== wr_e.a || mem_wdata !== wr_e.d) begin
            n_fail++;
            $display("FAIL wr addr=%0h data=%0h expected addr=%0h data=%0h",
                     mem_waddr, mem_wdata, wr_e.a, wr_e.d);
          end
        end
      end
      if (mem_we || tx_start) begin
        n_checks++;
        if (mem_we && tx_start) begin
          n_fail++;
          $display("FAIL excl mem_we=%b tx_start=%b expected not both",
                   mem_we, tx_start);
        end
      end
      if (proc_start) begin
        proc_cnt++;
        proc_cyc = cyc;
      end
      if (frame_done) fd_cnt++;
    end
  end

  int         tx_lat = 0;
  int         tx_low = 1;
  int         txm_cnt = 0;
  int         txm_n = 0;
  bit         txm_busy = 1'b0;
  logic [7:0] txm_byte = '0;
  logic [7:0] tx_e;

  // Transmitter model with configurable accept latency and busy time
  always @(negedge clk) begin
    if (!rst) begin
      tx_ready = 1'b1;
      txm_busy = 1'b0;
      txm_cnt  = 0;
    end else if (!txm_busy) begin
      if (tx_start && tx_ready) begin
        txm_busy = 1'b1;
        txm_cnt  = 0;
        txm_byte = tx_data;
        txm_n++;
        n_checks++;
        if (exp_tx.size() == 0) begin
          n_fail++;
          $display("FAIL tx_extra got=%0h expected none", tx_data);
        end else begin
          tx_e = exp_tx.pop_front();
          if (tx_data !== tx_e) begin
            n_fail++;
            $display("FAIL tx_byte got=%0h expected=%0h", tx_data, tx_e);
          end
        end
      end
    end else if (tx_ready) begin
      txm_cnt++;
      n_checks++;
      if (tx_start !== 1'b1 || tx_data !== txm_byte) begin
        n_fail++;
        $display("FAIL tx_hold tx_start=%b data=%0h expected 1 %0h",
                 tx_start, tx_data, txm_byte);
      end
      if (txm_cnt >= tx_lat) begin
        tx_ready = 1'b0;
        txm_cnt  = 0;
      end
    end else begin
      txm_cnt++;
      if (txm_cnt >= tx_low) begin
        tx_ready = 1'b1;
        txm_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data = b;
    rx_ready = 1'b1;
    last_rx_cyc = cyc;
    repeat (hold) @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input int hold);
    for (int i = 0; i < NUM; i++) begin
      exp_wr.push_back({AW'(i), in_w[i]});
      send_byte(in_w[i][7:0], hold);
      send_byte(in_w[i][15:8], hold);
    end
  endtask

  task automatic wait_proc_start(input int base);
    int k;
    k = 0;
    while (proc_cnt == base && k < 2000) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (proc_cnt == base) begin
      n_fail++;
      $display("FAIL proc_start_timeout got none expected pulse");
    end else if (proc_cyc != last_rx_cyc + 2) begin
      n_fail++;
      $display("FAIL proc_latency got=%0d expected=2",
               proc_cyc - last_rx_cyc);
    end
  endtask

  task automatic run_proc(input bit ign);
    int tn;
    for (int i = 0; i < NUM; i++) begin
      res_mem[i] = out_w[i];
      exp_tx.push_back(out_w[i][7:0]);
      exp_tx.push_back(out_w[i][15:8]);
    end
    if (ign) begin
      while (cyc < proc_cyc + 1) @(negedge clk);
      tn = txm_n;
      n_checks++;
      if (cyc != proc_cyc + 1) begin
        n_fail++;
        $display("FAIL stale_sync cyc=%0d expected=%0d", cyc, proc_cyc + 1);
      end
      proc_done = 1'b1;
      @(negedge clk);
      proc_done = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (tx_start !== 1'b0 || txm_n != tn || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stale_done tx_start=%b sent=%0d busy=%b expected 0 0 1",
                 tx_start, txm_n - tn, busy);
      end
    end
    @(negedge clk);
    proc_done = 1'b1;
    @(negedge clk);
    proc_done = 1'b0;
  endtask

  task automatic finish_frame(input int pb, input int fb);
    int k;
    k = 0;
    while (fd_cnt == fb && k < 20000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (fd_cnt != fb + 1) begin
      n_fail++;
      $display("FAIL frame_done count=%0d expected=1", fd_cnt - fb);
    end
    n_checks++;
    if (exp_tx.size() != 0) begin
      n_fail++;
      $display("FAIL tx_missing left=%0d expected=0", exp_tx.size());
    end
    n_checks++;
    if (proc_cnt != pb + 1) begin
      n_fail++;
      $display("FAIL proc_count got=%0d expected=1", proc_cnt - pb);
    end
    n_checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b0 || res_raddr !== '0) begin
      n_fail++;
      $display("FAIL end_state busy=%b err=%b raddr=%0h expected 0 0 0",
               busy, err_timeout, res_raddr);
    end
  endtask

  task automatic full_frame(input int hold, input bit ign);
    int pb;
    int fb;
    pb = proc_cnt;
    fb = fd_cnt;
    send_frame(hold);
    wait_proc_start(pb);
    run_proc(ign);
    finish_frame(pb, fb);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 16; i++) res_mem[i] = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_start, mem_we, proc_start, busy, frame_done, err_timeout}
        !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b expected=000000",
               {tx_start, mem_we, proc_start, busy, frame_done, err_timeout});
    end
    n_checks++;
    if (tx_data !== 8'h00 || mem_wdata !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data tx=%0h wdata=%0h expected 0 0",
               tx_data, mem_wdata);
    end
    n_checks++;
    if (mem_waddr !== '0 || res_raddr !== '0) begin
      n_fail++;
      $display("FAIL reset_addr waddr=%0h raddr=%0h expected 0 0",
               mem_waddr, res_raddr);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset busy=%b we=%b expected 0 0", busy, mem_we);
    end
  endtask

  task automatic test_basic_frame;
    in_w[0] = 16'h2211; in_w[1] = 16'h4433; in_w[2] = 16'h6655;
    out_w[0] = 16'hBBAA; out_w[1] = 16'hDDCC; out_w[2] = 16'h0FEE;
    full_frame(1, 1'b1);
  endtask

  task automatic test_long_rx_ready;
    in_w[0] = 16'h1234; in_w[1] = 16'h5678; in_w[2] = 16'h9ABC;
    out_w[0] = 16'h0102; out_w[1] = 16'h0304; out_w[2] = 16'h0506;
    full_frame(50, 1'b0);
  endtask

  task automatic test_timeout;
    int pb;
    int fb;
    pb = proc_cnt;
    fb = fd_cnt;
    exp_wr.push_back({AW'(0), 16'hA1B2});
    send_byte(8'hB2, 1);
    send_byte(8'hA1, 1);
    send_byte(8'h77, 1);
    repeat (96) @(negedge clk);
    n_checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_early err=%b busy=%b expected 0 1",
               err_timeout, busy);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_abort err=%b busy=%b expected 1 0",
               err_timeout, busy);
    end
    repeat (50) @(negedge clk);
    n_checks++;
    if (proc_cnt != pb || err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_hold proc=%0d err=%b expected 0 1",
               proc_cnt - pb, err_timeout);
    end
    in_w[0] = 16'hC0DE; in_w[1] = 16'hBEEF; in_w[2] = 16'h00FF;
    out_w[0] = 16'h5A5A; out_w[1] = 16'hA5A5; out_w[2] = 16'h1001;
    for (int i = 0; i < NUM; i++) exp_wr.push_back({AW'(i), in_w[i]});
    send_byte(in_w[0][7:0], 1);
    n_checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_clear err=%b busy=%b expected 0 1",
               err_timeout, busy);
    end
    send_byte(in_w[0][15:8], 1);
    for (int i = 1; i < NUM; i++) begin
      send_byte(in_w[i][7:0], 1);
      send_byte(in_w[i][15:8], 1);
    end
    wait_proc_start(pb);
    run_proc(1'b0);
    finish_frame(pb, fb);
  endtask

  task automatic test_slow_tx;
    tx_lat = 3;
    tx_low = 1000;
    in_w[0] = 16'h0A0B; in_w[1] = 16'h0C0D; in_w[2] = 16'h0E0F;
    out_w[0] = 16'h7766; out_w[1] = 16'h9988; out_w[2] = 16'h3322;
    full_frame(1, 1'b0);
    tx_lat = 0;
    tx_low = 1;
  endtask

  task automatic test_back_to_back;
    in_w[0] = 16'h1111; in_w[1] = 16'h2222; in_w[2] = 16'h3333;
    out_w[0] = 16'h4444; out_w[1] = 16'h5555; out_w[2] = 16'h6666;
    full_frame(1, 1'b0);
    in_w[0] = 16'hFEDC; in_w[1] = 16'hBA98; in_w[2] = 16'h7654;
    out_w[0] = 16'h3210; out_w[1] = 16'h8421; out_w[2] = 16'h1248;
    full_frame(2, 1'b0);
  endtask

  task automatic test_reset_mid_send;
    int pb;
    int t0;
    int tn;
    int k;
    pb = proc_cnt;
    t0 = txm_n;
    in_w[0] = 16'h0102; in_w[1] = 16'h0304; in_w[2] = 16'h0506;
    out_w[0] = 16'hE1E0; out_w[1] = 16'hE3E2; out_w[2] = 16'hE5E4;
    send_frame(1);
    wait_proc_start(pb);
    run_proc(1'b0);
    k = 0;
    while (!(txm_n == t0 + 3 && tx_start === 1'b1) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (txm_n != t0 + 3 || tx_start !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_send_reach sent=%0d expected=3", txm_n - t0);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({tx_start, mem_we, proc_start, busy, frame_done, err_timeout}
        !== 6'b0 || tx_data !== 8'h00 || res_raddr !== '0) begin
      n_fail++;
      $display("FAIL mid_reset ctrl=%b tx=%0h raddr=%0h expected all 0",
               {tx_start, mem_we, proc_start, busy, frame_done, err_timeout},
               tx_data, res_raddr);
    end
    exp_tx.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tn = txm_n;
    repeat (200) @(negedge clk);
    n_checks++;
    if (txm_n != tn || tx_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_mid_reset sent=%0d tx_start=%b busy=%b expected 0",
               txm_n - tn, tx_start, busy);
    end
  endtask

  task automatic test_recovery;
    in_w[0] = 16'h1357; in_w[1] = 16'h2468; in_w[2] = 16'hACE0;
    out_w[0] = 16'hBDF1; out_w[1] = 16'h0246; out_w[2] = 16'h8ACE;
    full_frame(1, 1'b0);
    n_checks++;
    if (exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL wr_missing left=%0d expected=0", exp_wr.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_long_rx_ready();
    test_timeout();
    test_slow_tx();
    test_back_to_back();
    test_reset_mid_send();
    test_recovery();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
